// File: rtl/spi_adc_sequencer.sv
// -----------------------------------------------------------------------------
// spi_adc_sequencer
//
// Scan scheduler for the 12-bit SPI ADC front end. A programmable sample-period
// timer triggers scans; each scan converts every enabled channel in ascending
// index order through a start/busy/done handshake with the SPI state machine.
// Each result is presented with its channel tag to downstream consumers.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   Defined   : a WAIT_DONE watchdog abandons a conversion after TIMEOUT_CYC
//               cycles without spi_done, sets sticky timeout_err and continues
//               the scan with the next channel.
//   Undefined : WAIT_DONE waits indefinitely; timeout_err is tied to 0.
//
// Ports:
//   clk          block clock
//   rst_n        asynchronous active-low reset
//   ena          sequencer enable; low forces IDLE
//   ch_mask      channel enable mask, bit i enables channel i
//   period       scan period in clk cycles (0 is treated as 1)
//   spi_start    one-cycle conversion request to the SPI state machine
//   spi_ch       channel of the current request, stable until spi_done
//   spi_busy     SPI state machine busy
//   spi_done     one-cycle pulse, spi_data valid
//   spi_data     conversion result
//   res_valid    one-cycle result strobe
//   res_ch       channel of the result
//   res_data     result value, held until the next res_valid
//   scan_done    one-cycle pulse with the last result of a scan
//   overrun      sticky: a tick arrived while a scan was in progress
//   timeout_err  sticky: a conversion timed out
// -----------------------------------------------------------------------------
module spi_adc_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int PERIOD_W    = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [PERIOD_W-1:0] period,
    output logic                spi_start,
    output logic [CH_W-1:0]     spi_ch,
    input  logic                spi_busy,
    input  logic                spi_done,
    input  logic [11:0]         spi_data,
    output logic                res_valid,
    output logic [CH_W-1:0]     res_ch,
    output logic [11:0]         res_data,
    output logic                scan_done,
    output logic                overrun,
    output logic                timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        ISSUE,
        WAIT_DONE,
        NEXT
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] period_eff;
    logic                tick;
    logic [NUM_CH-1:0]   scan_mask;   // channels of the current scan not yet issued
    logic                abort;       // conversion abandoned by the watchdog

    generate
        if ((2 ** CH_W) < NUM_CH || NUM_CH < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
            $error("spi_adc_sequencer: illegal parameter combination");
        end
    endgenerate

    // Lowest set index of a mask; 0 when the mask is empty.
    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------ timer
    always_comb period_eff = (period == '0) ? PERIOD_W'(1) : period;

    assign tick = ena && (cnt == (period_eff - PERIOD_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!ena || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

    // --------------------------------------------------------------- watchdog
`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;

    // Held at zero outside WAIT_DONE, so every entry starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state != WAIT_DONE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign abort = ena && (state == WAIT_DONE) && !spi_done &&
                   (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (state == IDLE) begin
            timeout_err <= 1'b0;
        end else if (abort) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // spi_start and scan_done are decoded from state so they can never
    // outlive the state that owns them; ena gates both immediately.
    always_comb begin
        state_nx  = state;
        spi_start = 1'b0;
        scan_done = 1'b0;
        if (!ena) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:      state_nx = WAIT_TICK;
                WAIT_TICK: if (tick && ch_mask != '0) state_nx = ISSUE;
                ISSUE: begin
                    if (!spi_busy) begin
                        spi_start = 1'b1;
                        state_nx  = WAIT_DONE;
                    end
                end
                WAIT_DONE: if (spi_done || abort) state_nx = NEXT;
                NEXT: begin
                    if (scan_mask != '0) begin
                        state_nx = ISSUE;
                    end else begin
                        scan_done = 1'b1;
                        state_nx  = WAIT_TICK;
                    end
                end
                default:   state_nx = IDLE;
            endcase
        end
    end

    // ------------------------------------------------- channel / result path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_mask <= '0;
            spi_ch    <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (!ena) begin
                scan_mask <= '0;
            end else begin
                case (state)
                    WAIT_TICK: begin
                        if (tick && ch_mask != '0) begin
                            scan_mask <= ch_mask;
                            spi_ch    <= lowest_ch(ch_mask);
                        end
                    end
                    // Retire the channel once issued; NEXT then only looks
                    // at what is left of the scan.
                    ISSUE: begin
                        if (!spi_busy) scan_mask <= scan_mask & ~(NUM_CH'(1) << spi_ch);
                    end
                    WAIT_DONE: begin
                        if (spi_done) begin
                            res_valid <= 1'b1;
                            res_data  <= spi_data;
                            res_ch    <= spi_ch;
                        end
                    end
                    NEXT: begin
                        if (scan_mask != '0) spi_ch <= lowest_ch(scan_mask);
                    end
                    default: ;
                endcase
            end

            if (state == IDLE) begin
                overrun <= 1'b0;
            end else if (tick && (state == ISSUE || state == WAIT_DONE || state == NEXT)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for spi_adc_sequencer. An SPI model answers each spi_start after a
// configurable latency and records the stimulus data it returns; results are
// collected in queues and compared by scenario tasks against the bench's own
// expectations (channel order from the mask, data from the model).
// -----------------------------------------------------------------------------
module tb_spi_adc_sequencer;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ena      = 1'b0;
    logic [3:0]  ch_mask  = '0;
    logic [15:0] period   = '0;
    logic        spi_busy = 1'b0;
    logic        spi_done = 1'b0;
    logic [11:0] spi_data = '0;
    logic        spi_start;
    logic [1:0]  spi_ch;
    logic        res_valid;
    logic [1:0]  res_ch;
    logic [11:0] res_data;
    logic        scan_done;
    logic        overrun;
    logic        timeout_err;

    spi_adc_sequencer #(
        .NUM_CH     (4),
        .CH_W       (2),
        .PERIOD_W   (16),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ch_mask    (ch_mask),
        .period     (period),
        .spi_start  (spi_start),
        .spi_ch     (spi_ch),
        .spi_busy   (spi_busy),
        .spi_done   (spi_done),
        .spi_data   (spi_data),
        .res_valid  (res_valid),
        .res_ch     (res_ch),
        .res_data   (res_data),
        .scan_done  (scan_done),
        .overrun    (overrun),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ch;
        logic [11:0] data;
    } ent_t;

    // model configuration (written by scenario tasks only)
    int          cfg_lat   = 20;
    bit          cfg_fixed = 1'b0;
    logic [11:0] cfg_data  = '0;
    int          cfg_skip  = -1;

    // model / monitor state (written by the monitor only)
    int   cyc       = 0;
    int   start_cnt = 0;
    int   res_cnt   = 0;
    int   sd_cnt    = 0;
    int   sd_rv_cnt = 0;
    int   unstable  = 0;
    ent_t done_q[$];        // what the model returned: channel asked for, data
    ent_t res_q[$];         // what the DUT presented
    int   start_cyc_q[$];
    bit   pend = 1'b0;
    int   left = 0;
    logic [1:0] pch = '0;

    int checks = 0;
    int errors = 0;

    // Inputs from tasks change on the falling edge; this samples 1 time unit
    // later and drives spi_done/spi_data for the following rising edge.
    always @(negedge clk) begin
        ent_t e;
        #1;
        cyc++;
        spi_done = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else if (spi_start) begin
            start_cnt++;
            start_cyc_q.push_back(cyc);
            pend = 1'b1;
            left = cfg_lat;
            pch  = spi_ch;
        end else if (pend) begin
            if (spi_ch !== pch) unstable++;
            left--;
            if (left <= 0) begin
                pend = 1'b0;
                if (cfg_skip != int'(pch)) begin
                    spi_data = cfg_fixed ? cfg_data : 12'($urandom);
                    spi_done = 1'b1;
                    e.ch     = pch;
                    e.data   = spi_data;
                    done_q.push_back(e);
                end
            end
        end
        if (res_valid) begin
            res_cnt++;
            e.ch   = res_ch;
            e.data = res_data;
            res_q.push_back(e);
        end
        if (scan_done) begin
            sd_cnt++;
            if (res_valid) sd_rv_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n-th channel (wrapping per scan) of an ascending scan over mask m
    function automatic int nth_ch(input logic [3:0] m, input int n);
        int p;
        int k;
        int r;
        p = 0;
        r = -1;
        for (int i = 0; i < 4; i++) if (m[i]) p++;
        if (p == 0) return -1;
        k = n % p;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (k == 0 && r < 0) r = i;
                k--;
            end
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; ch_mask = 4'hF; period = 16'd5; spi_busy = 1'b0;
        step(4); #2;
        checks++;
        if ({spi_start, res_valid, scan_done, overrun, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000", {spi_start, res_valid, scan_done, overrun, timeout_err});
        end
        checks++;
        if (spi_ch !== 2'd0) begin errors++; $display("FAIL reset_spi_ch got %0d want 0", spi_ch); end
        checks++;
        if (res_ch !== 2'd0) begin errors++; $display("FAIL reset_res_ch got %0d want 0", res_ch); end
        checks++;
        if (res_data !== 12'd0) begin errors++; $display("FAIL reset_res_data got %h want 000", res_data); end
        checks++;
        if (start_cnt != 0) begin errors++; $display("FAIL reset_no_start got %0d starts want 0", start_cnt); end
        @(negedge clk);
        ena = 1'b0;
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic test_basic_scan();
        int b_res, b_done, b_st, b_sd, b_sdrv, n;
        @(negedge clk);
        period = 16'd100; ch_mask = 4'b1011; cfg_lat = 20;
        b_res = res_q.size(); b_done = done_q.size(); b_st = start_cyc_q.size();
        b_sd = sd_cnt; b_sdrv = sd_rv_cnt;
        ena = 1'b1;
        step(290); #2;
        n = res_q.size() - b_res;
        checks++;
        if (n != 6) begin errors++; $display("FAIL basic_res_count got %0d want 6", n); end
        if (n > 6) n = 6;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (int'(res_q[b_res+i].ch) !== nth_ch(4'b1011, i)) begin
                errors++; $display("FAIL basic_res_ch[%0d] got %0d want %0d", i, res_q[b_res+i].ch, nth_ch(4'b1011, i));
            end
            checks++;
            if (int'(done_q[b_done+i].ch) !== nth_ch(4'b1011, i)) begin
                errors++; $display("FAIL basic_spi_ch[%0d] got %0d want %0d", i, done_q[b_done+i].ch, nth_ch(4'b1011, i));
            end
            checks++;
            if (res_q[b_res+i].data !== done_q[b_done+i].data) begin
                errors++; $display("FAIL basic_res_data[%0d] got %h want %h", i, res_q[b_res+i].data, done_q[b_done+i].data);
            end
        end
        checks++;
        if (sd_cnt - b_sd != 2) begin errors++; $display("FAIL basic_scan_done got %0d want 2", sd_cnt - b_sd); end
        checks++;
        if (sd_rv_cnt - b_sdrv != 2) begin errors++; $display("FAIL basic_scan_done_with_res got %0d want 2", sd_rv_cnt - b_sdrv); end
        checks++;
        if (start_cyc_q.size() < b_st + 4) begin
            errors++; $display("FAIL basic_start_count got %0d want >=4", start_cyc_q.size() - b_st);
        end else if (start_cyc_q[b_st+3] - start_cyc_q[b_st] != 100) begin
            errors++; $display("FAIL basic_scan_spacing got %0d want 100", start_cyc_q[b_st+3] - start_cyc_q[b_st]);
        end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun got %b want 0", overrun); end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL basic_spi_ch_stable got %0d changes want 0", unstable); end
        @(negedge clk);
        ena = 1'b0;
        step(40);
    endtask

    task automatic test_overrun();
        int b_res, b_done, n;
        @(negedge clk);
        period = 16'd30; ch_mask = 4'hF; cfg_lat = 20;
        b_res = res_q.size(); b_done = done_q.size();
        ena = 1'b1;
        step(45); #2;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_before got %b want 0", overrun); end
        step(30); #2;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun); end
        step(145); #2;
        n = res_q.size() - b_res;
        checks++;
        if (n < 4) begin errors++; $display("FAIL overrun_res_count got %0d want >=4", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (int'(res_q[b_res+i].ch) !== (i % 4)) begin
                errors++; $display("FAIL overrun_order[%0d] got %0d want %0d", i, res_q[b_res+i].ch, i % 4);
            end
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (res_q[b_res+i].data !== done_q[b_done+i].data) begin
                errors++; $display("FAIL overrun_data[%0d] got %h want %h", i, res_q[b_res+i].data, done_q[b_done+i].data);
            end
        end
        @(negedge clk);
        ena = 1'b0;
        step(2); #2;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear_idle got %b want 0", overrun); end
        step(40);
    endtask

    task automatic test_empty_mask();
        int b_st, b_res, b_sd;
        @(negedge clk);
        period = 16'd10; ch_mask = 4'b0000;
        b_st = start_cnt; b_res = res_cnt; b_sd = sd_cnt;
        ena = 1'b1;
        step(100); #2;
        checks++;
        if (start_cnt != b_st) begin errors++; $display("FAIL empty_start got %0d want 0", start_cnt - b_st); end
        checks++;
        if (res_cnt != b_res) begin errors++; $display("FAIL empty_res_valid got %0d want 0", res_cnt - b_res); end
        checks++;
        if (sd_cnt != b_sd) begin errors++; $display("FAIL empty_scan_done got %0d want 0", sd_cnt - b_sd); end
        @(negedge clk);
        ena = 1'b0;
        step(3);
    endtask

    task automatic test_busy();
        int b_st, b_res, b_done, b_unst;
        @(negedge clk);
        period = 16'd50; ch_mask = 4'b0001; cfg_lat = 10; spi_busy = 1'b1;
        b_st = start_cnt; b_res = res_q.size(); b_done = done_q.size(); b_unst = unstable;
        ena = 1'b1;
        step(54); #2;
        checks++;
        if (start_cnt != b_st) begin errors++; $display("FAIL busy_hold_start got %0d want 0", start_cnt - b_st); end
        @(negedge clk);
        spi_busy = 1'b0;
        #2;
        checks++;
        if (start_cnt - b_st != 1 || start_cyc_q[$] != cyc) begin
            errors++; $display("FAIL busy_release_start got %0d starts want 1 in cycle %0d", start_cnt - b_st, cyc);
        end
        step(20); #2;
        checks++;
        if (start_cnt - b_st != 1) begin errors++; $display("FAIL busy_single_start got %0d want 1", start_cnt - b_st); end
        checks++;
        if (res_q.size() - b_res != 1) begin
            errors++; $display("FAIL busy_res_count got %0d want 1", res_q.size() - b_res);
        end else if (res_q[b_res].ch !== 2'd0 || res_q[b_res].data !== done_q[b_done].data) begin
            errors++; $display("FAIL busy_res got ch%0d %h want ch0 %h", res_q[b_res].ch, res_q[b_res].data, done_q[b_done].data);
        end
        checks++;
        if (unstable != b_unst) begin errors++; $display("FAIL busy_spi_ch_stable got %0d changes want 0", unstable - b_unst); end
        @(negedge clk);
        ena = 1'b0;
        step(30);
    endtask

    task automatic test_ena_abort();
        int b_st, b_res, b_done, k, r0;
        logic [11:0] d_hold;
        @(negedge clk);
        period = 16'd20; ch_mask = 4'b0110; cfg_lat = 20; cfg_fixed = 1'b0;
        b_st = start_cnt; b_res = res_q.size(); b_done = done_q.size();
        ena = 1'b1;
        k = 0;
        while (start_cnt - b_st < 2 && k < 200) begin
            step(1); #2;
            k++;
        end
        checks++;
        if (k >= 200) begin errors++; $display("FAIL abort_wait_second_start got %0d starts want 2", start_cnt - b_st); end
        cfg_fixed = 1'b1;
        cfg_data  = 12'hABC;
        d_hold = done_q[b_done].data;
        r0 = res_q.size();
        checks++;
        if (r0 - b_res != 1 || res_q[b_res].ch !== 2'd1) begin
            errors++; $display("FAIL abort_first_result got %0d results want 1 on ch1", r0 - b_res);
        end
        step(17);
        ena = 1'b0;
        step(10); #2;
        checks++;
        if (done_q.size() - b_done != 2) begin
            errors++; $display("FAIL abort_late_done got %0d dones want 2", done_q.size() - b_done);
        end
        checks++;
        if (res_q.size() != r0) begin errors++; $display("FAIL abort_no_res_valid got %0d want 0", res_q.size() - r0); end
        checks++;
        if (res_data !== d_hold) begin errors++; $display("FAIL abort_res_data_hold got %h want %h", res_data, d_hold); end
        checks++;
        if (res_ch !== 2'd1) begin errors++; $display("FAIL abort_res_ch_hold got %0d want 1", res_ch); end
        cfg_fixed = 1'b0;
        @(negedge clk);
        b_res = res_q.size(); b_done = done_q.size();
        ena = 1'b1;
        step(60); #2;
        checks++;
        if (res_q.size() == b_res) begin
            errors++; $display("FAIL abort_restart got 0 results want >=1");
        end else if (res_q[b_res].ch !== 2'd1 || done_q[b_done].ch !== 2'd1 || res_q[b_res].data !== done_q[b_done].data) begin
            errors++; $display("FAIL abort_restart got ch%0d %h want ch1 %h", res_q[b_res].ch, res_q[b_res].data, done_q[b_done].data);
        end
        @(negedge clk);
        ena = 1'b0;
        step(40);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        period = 16'd10; ch_mask = 4'hF; cfg_lat = 5;
        ena = 1'b1;
        step(20);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({spi_start, res_valid, scan_done, overrun, timeout_err} !== 5'b0) begin
            errors++; $display("FAIL async_reset_strobes got %b want 00000", {spi_start, res_valid, scan_done, overrun, timeout_err});
        end
        checks++;
        if (spi_ch !== 2'd0 || res_ch !== 2'd0 || res_data !== 12'd0) begin
            errors++; $display("FAIL async_reset_data got spi_ch %0d res_ch %0d res_data %h want 0 0 000", spi_ch, res_ch, res_data);
        end
        @(negedge clk);
        ena = 1'b0;
        rst_n = 1'b1;
        step(10);
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int b_st, b_res, b_done, b_sd;
        @(negedge clk);
        period = 16'd100; ch_mask = 4'b0011; cfg_lat = 10; cfg_skip = 1;
        b_st = start_cnt; b_res = res_q.size(); b_done = done_q.size(); b_sd = sd_cnt;
        ena = 1'b1;
        step(120); #2;
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", timeout_err); end
        step(30); #2;
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", timeout_err); end
        checks++;
        if (res_q.size() - b_res != 1) begin
            errors++; $display("FAIL timeout_res_count got %0d want 1", res_q.size() - b_res);
        end else if (res_q[b_res].ch !== 2'd0 || res_q[b_res].data !== done_q[b_done].data) begin
            errors++; $display("FAIL timeout_ch0 got ch%0d %h want ch0 %h", res_q[b_res].ch, res_q[b_res].data, done_q[b_done].data);
        end
        checks++;
        if (sd_cnt - b_sd != 1) begin errors++; $display("FAIL timeout_scan_done got %0d want 1", sd_cnt - b_sd); end
        checks++;
        if (start_cnt - b_st != 2) begin errors++; $display("FAIL timeout_starts got %0d want 2", start_cnt - b_st); end
        @(negedge clk);
        ena = 1'b0; cfg_skip = -1;
        step(3); #2;
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear_idle got %b want 0", timeout_err); end
        step(10);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_scan();
        test_overrun();
        test_empty_mask();
        test_busy();
        test_ena_abort();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
